// File: rtl/seq_div.sv
// Iterative unsigned restoring divider: a DW-bit dividend divided by an (Nbits+1)-bit divisor,
// producing one quotient bit per clock behind a start/busy/done handshake.
module seq_div #(
  parameter  int unsigned Nbits = 5,
  localparam int unsigned DW    = 2 * Nbits + 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   dividend,
  input  logic [Nbits:0]  divisor,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [DW-1:0]   quotient,
  output logic [Nbits:0]  remainder
);

  localparam int unsigned CW = $clog2(DW);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [Nbits:0]  rem_q, rem_d;
  logic [DW-1:0]   wq_q, wq_d;
  logic [Nbits:0]  dvs_q, dvs_d;
  logic            zero_q, zero_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;
  logic [DW-1:0]   quot_q, quot_d;
  logic [Nbits:0]  remd_q, remd_d;

  logic [Nbits+1:0] trial;
  logic [Nbits:0]   diff;
  logic             ge;
  logic [Nbits:0]   step_rem;
  logic [DW-1:0]    step_q;

  // Trial is one bit wider than the divisor so the compare cannot overflow; when it succeeds the
  // difference is below the divisor, so the low Nbits+1 bits of the subtraction are exact.
  always_comb begin
    trial    = {rem_q, wq_q[DW-1]};
    ge       = trial >= {1'b0, dvs_q};
    diff     = trial[Nbits:0] - dvs_q;
    step_rem = ge ? diff : trial[Nbits:0];
    step_q   = {wq_q[DW-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    wq_d    = wq_q;
    dvs_d   = dvs_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          dvs_d   = divisor;
          rem_d   = '0;
          wq_d    = dividend;
          cnt_d   = CW'(DW - 1);
          zero_d  = (divisor == '0);
          busy_d  = 1'b1;
          dbz_d   = 1'b0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (zero_q) begin
          quot_d  = '1;
          remd_d  = '0;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StDone;
        end else begin
          rem_d = step_rem;
          wq_d  = step_q;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            quot_d  = step_q;
            remd_d  = step_rem;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      wq_q    <= '0;
      dvs_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      remd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      wq_q    <= wq_d;
      dvs_q   <= dvs_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quot_q;
  assign remainder   = remd_q;

endmodule
